z_mem_reader: RTL and testbench

Z_MEM_READER -- requirements
Module: z_mem_reader

---
 rtl/z_mem_reader_if.sv | 27 ++
 rtl/z_mem_reader.sv | 114 +++++++++++
 tb/tb_z_mem_reader.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/z_mem_reader_if.sv
// Bundle of control, memory-read and stream signals for z_mem_reader.
// The slave modport is the reader's view; master is the environment's view.
interface z_mem_reader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
);
    logic                  start_i;
    logic [ADDR_WIDTH-1:0] base_addr_i;
    logic [ADDR_WIDTH:0]   len_i;
    logic [ADDR_WIDTH-1:0] read_addr_o;
    logic [DATA_WIDTH-1:0] read_data_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  valid_o;
    logic                  ready_i;
    logic                  busy_o;
    logic                  done_o;

    modport slave (
        input  start_i, base_addr_i, len_i, read_data_i, ready_i,
        output read_addr_o, data_o, valid_o, busy_o, done_o
    );

    modport master (
        output start_i, base_addr_i, len_i, read_data_i, ready_i,
        input  read_addr_o, data_o, valid_o, busy_o, done_o
    );
endinterface

// File: rtl/z_mem_reader.sv
// Streams len words from a registered-output result memory, starting at base,
// through a 2-entry FIFO with valid/ready handshake.
module z_mem_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
) (
    input logic             clk,
    input logic             rstn,
    z_mem_reader_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   issued_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  inflight_q;
    logic [1:0]            count_q;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;
    logic                  pop;
    logic                  issue;
    logic                  accept;
    logic [2:0]            occ;

    assign pop = (count_q != 2'd0) && bus.ready_i;
    // Occupancy after this edge if nothing new is issued; a read may be issued only if room remains
    assign occ = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    accept  = 1'b1;
                    state_d = (bus.len_i == '0) ? FINISH : READ;
                end
            end
            READ: begin
                if ((issued_q < len_q) && (occ < 3'd2)) begin
                    issue = 1'b1;
                    if (issued_q + CNT_ONE == len_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // All reads issued: the last transfer pops the only remaining word
                if (pop && (count_q == 2'd1) && !inflight_q) state_d = FINISH;
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            if (accept) begin
                len_q    <= bus.len_i;
                issued_q <= '0;
                if (bus.len_i != '0) addr_q <= bus.base_addr_i;
            end else if (issue) begin
                issued_q <= issued_q + CNT_ONE;
                addr_q   <= addr_q + ADDR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            case ({inflight_q, pop})
                2'b10: begin
                    if (count_q == 2'd0) head_q <= bus.read_data_i;
                    else                 tail_q <= bus.read_data_i;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) head_q <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_q <= bus.read_data_i;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= bus.read_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.read_addr_o = addr_q;
    assign bus.data_o      = head_q;
    assign bus.valid_o     = (count_q != 2'd0);
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.done_o      = (state_q == FINISH);
endmodule

// File: tb/tb_z_mem_reader.sv
// Directed bench for z_mem_reader: table of readouts plus reset corner cases.
module tb_z_mem_reader;
    logic clk;
    logic rstn;
    int   checks;
    int   failures;

    z_mem_reader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) bus ();

    z_mem_reader #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    logic [15:0] mem [64];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bus.read_data_i <= mem[bus.read_addr_o];

    typedef struct {
        logic [5:0]  base;
        logic [6:0]  len;
        logic [3:0]  pat;
        logic        mid_start;
        int          exp_count;
        logic [15:0] exp_first;
        logic [15:0] exp_last;
        int          exp_busy;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int          transfers = 0;
        int          issues    = 0;
        int          busy_cnt  = 0;
        int          done_cnt  = 0;
        int          first_v   = -1;
        logic [15:0] first_d   = '0;
        logic [15:0] last_d    = '0;
        logic        order_ok  = 1'b1;
        logic        stall_ok  = 1'b1;
        logic        outst_ok  = 1'b1;
        logic        addr0_ok  = 1'b1;
        logic        stalled   = 1'b0;
        logic [15:0] stall_d   = '0;
        logic [5:0]  prev_a;
        logic [5:0]  a;
        logic        finished  = 1'b0;
        int          c         = 0;
        int          idle_bad  = 0;
        prev_a          = bus.read_addr_o;
        bus.base_addr_i = v.base;
        bus.len_i       = v.len;
        bus.start_i     = 1'b1;
        bus.ready_i     = 1'b0;
        while (!finished && c < 200) begin
            @(negedge clk);
            c++;
            if (bus.busy_o) busy_cnt++;
            if (bus.done_o) done_cnt++;
            if (bus.valid_o && first_v < 0) first_v = c;
            if (c == 1 && v.len != 0 && bus.read_addr_o != v.base) addr0_ok = 1'b0;
            if ((c >= 2 || v.len == 0) && bus.read_addr_o != prev_a) issues++;
            prev_a = bus.read_addr_o;
            if (issues - transfers > 2) outst_ok = 1'b0;
            if (stalled && (!bus.valid_o || bus.data_o != stall_d)) stall_ok = 1'b0;
            bus.start_i = (v.mid_start && c == 20);
            if (v.mid_start && c == 20) begin
                bus.base_addr_i = 6'd7;
                bus.len_i       = 7'd3;
            end
            bus.ready_i = v.pat[(c - 1) % 4];
            stalled = bus.valid_o && !bus.ready_i;
            stall_d = bus.data_o;
            if (bus.valid_o && bus.ready_i) begin
                a = v.base + 6'(transfers);
                if (bus.data_o != 16'h100 + {10'b0, a}) order_ok = 1'b0;
                if (transfers == 0) first_d = bus.data_o;
                last_d = bus.data_o;
                transfers++;
            end
            if (done_cnt > 0 && !bus.busy_o) finished = 1'b1;
        end
        bus.start_i = 1'b0;
        check($sformatf("v%0d_timeout", id), finished, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.busy_o || bus.valid_o || bus.done_o) idle_bad++;
        end
        check($sformatf("v%0d_count", id), transfers, v.exp_count);
        check($sformatf("v%0d_issues", id), issues, v.exp_count);
        check($sformatf("v%0d_done_pulses", id), done_cnt, 1);
        check($sformatf("v%0d_order", id), order_ok, 1'b1);
        check($sformatf("v%0d_stall_stable", id), stall_ok, 1'b1);
        check($sformatf("v%0d_outstanding", id), outst_ok, 1'b1);
        check($sformatf("v%0d_idle_after", id), idle_bad, 0);
        if (v.exp_count > 0) begin
            check($sformatf("v%0d_first", id), first_d, v.exp_first);
            check($sformatf("v%0d_last", id), last_d, v.exp_last);
            check($sformatf("v%0d_first_valid_cycle", id), first_v, 3);
            check($sformatf("v%0d_start_addr", id), addr0_ok, 1'b1);
        end else begin
            check($sformatf("v%0d_no_valid", id), first_v, -1);
        end
        if (v.exp_busy > 0) check($sformatf("v%0d_busy_cycles", id), busy_cnt, v.exp_busy);
    endtask

    initial begin
        int tr;
        int bad;
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 64; i++) mem[i] = 16'h100 + 16'(i);
        vecs[0] = '{6'd0,  7'd4,  4'b1111, 1'b0, 4,  16'h100, 16'h103, 7};
        vecs[1] = '{6'd62, 7'd4,  4'b1111, 1'b0, 4,  16'h13E, 16'h101, 7};
        vecs[2] = '{6'd5,  7'd4,  4'b1001, 1'b0, 4,  16'h105, 16'h108, 0};
        vecs[3] = '{6'd9,  7'd0,  4'b1111, 1'b0, 0,  16'h000, 16'h000, 1};
        vecs[4] = '{6'd0,  7'd64, 4'b1111, 1'b1, 64, 16'h100, 16'h13F, 67};
        vecs[5] = '{6'd63, 7'd1,  4'b1111, 1'b0, 1,  16'h13F, 16'h13F, 4};
        vecs[6] = '{6'd10, 7'd2,  4'b1010, 1'b0, 2,  16'h10A, 16'h10B, 0};

        rstn            = 1'b0;
        bus.start_i     = 1'b0;
        bus.base_addr_i = '0;
        bus.len_i       = '0;
        bus.ready_i     = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {bus.read_addr_o, bus.data_o, bus.valid_o, bus.busy_o, bus.done_o}, '0);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Reset in the middle of a len=8 readout after two transfers
        bus.base_addr_i = 6'd0;
        bus.len_i       = 7'd8;
        bus.start_i     = 1'b1;
        bus.ready_i     = 1'b1;
        tr = 0;
        for (int c = 0; c < 50 && tr < 2; c++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            if (bus.valid_o && bus.ready_i) tr++;
        end
        check("rst_mid_two_transfers", tr, 2);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1 check("rst_mid_outputs",
                 {bus.read_addr_o, bus.data_o, bus.valid_o, bus.busy_o, bus.done_o}, '0);
        @(negedge clk);
        rstn = 1'b1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.valid_o || bus.done_o || bus.busy_o) bad++;
        end
        check("rst_mid_quiet_after", bad, 0);

        run_vec(7, vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
